// File: rtl/delete_order_event_queue.sv
// delete_order_event_queue
//
// Buffers completed ITCH Delete Order references from the 'D' decoder in a
// first-word-fall-through FIFO. Every accepted event is tagged with a
// wrapping sequence number and offered to the order-book stage over a
// valid/ready handshake. Invalid packets and FIFO-full drops are counted
// so that lost events can be observed.
//
// Ports
//   i_clk                    system clock, rising edge
//   i_rst                    asynchronous active-high reset
//   i_delete_internal_valid  decoder pulse: i_delete_order_ref is complete
//   i_delete_packet_invalid  decoder flag: current message is malformed
//   i_delete_order_ref       parsed 64-bit order reference
//   o_out_valid              head entry is valid
//   i_out_ready              consumer takes the head entry this cycle
//   o_out_order_ref          head entry order reference
//   o_out_seq                head entry sequence tag
//   o_fifo_count             occupancy, 0..DEPTH
//   o_full                   occupancy equals DEPTH
//   o_overflow_cnt           events dropped on a full FIFO (saturating)
//   o_invalid_cnt            cycles with i_delete_packet_invalid (saturating)

module delete_order_event_queue #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_delete_internal_valid,
  input  logic                     i_delete_packet_invalid,
  input  logic [63:0]              i_delete_order_ref,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [63:0]              o_out_order_ref,
  output logic [SEQ_W-1:0]         o_out_seq,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic                     o_full,
  output logic [CNT_W-1:0]         o_overflow_cnt,
  output logic [CNT_W-1:0]         o_invalid_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [SEQ_W-1:0] SEQ_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef struct packed {
    logic [63:0]      orderRef;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  // Storage and state
  entry_t           r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [SEQ_W-1:0] r_nextSeq;
  entry_t           r_head;
  logic [CNT_W-1:0] r_overflowCnt;
  logic [CNT_W-1:0] r_invalidCnt;

  // Combinational helpers
  logic        w_empty;
  logic        w_full;
  logic        w_pushReq;
  logic        w_pop;
  logic        w_accept;
  logic        w_drop;
  logic [AW:0] w_wrPtrNext;
  logic [AW:0] w_rdPtrNext;
  entry_t      w_newEntry;
  entry_t      w_nextHead;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty    = (r_wrPtr == r_rdPtr);
  assign w_full     = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_pushReq  = i_delete_internal_valid & ~i_delete_packet_invalid;
  assign w_pop      = ~w_empty & i_out_ready;
  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign w_accept   = w_pushReq & (~w_full | w_pop);
  assign w_drop     = w_pushReq & w_full & ~w_pop;
  assign w_newEntry = '{orderRef: i_delete_order_ref, seq: r_nextSeq};

  // Pointer advance and the value that will sit at the head after this edge.
  // The head register is refreshed from memory, except when the next head is
  // the very slot being written this cycle (push into empty, or push+pop at
  // a single entry); then the incoming entry is forwarded directly.
  always_comb begin
    w_wrPtrNext = r_wrPtr;
    w_rdPtrNext = r_rdPtr;
    w_nextHead  = r_head;
    if (w_accept) begin
      w_wrPtrNext = r_wrPtr + PTR_ONE;
    end
    if (w_pop) begin
      w_rdPtrNext = r_rdPtr + PTR_ONE;
    end
    if (w_wrPtrNext != w_rdPtrNext) begin
      if (w_accept && (w_rdPtrNext[AW-1:0] == r_wrPtr[AW-1:0])) begin
        w_nextHead = w_newEntry;
      end else begin
        w_nextHead = r_mem[w_rdPtrNext[AW-1:0]];
      end
    end
  end

  // Entry storage; contents are deliberately left alone by reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_mem[r_wrPtr[AW-1:0]] <= w_newEntry;
    end
  end

  // Pointers, head register and sequence tag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_head    <= '0;
      r_nextSeq <= '0;
    end else begin
      r_wrPtr <= w_wrPtrNext;
      r_rdPtr <= w_rdPtrNext;
      r_head  <= w_nextHead;
      if (w_accept) begin
        r_nextSeq <= r_nextSeq + SEQ_ONE;
      end
    end
  end

  // Loss counters stick at all-ones instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflowCnt <= '0;
      r_invalidCnt  <= '0;
    end else begin
      if (w_drop && (r_overflowCnt != '1)) begin
        r_overflowCnt <= r_overflowCnt + CNT_ONE;
      end
      if (i_delete_packet_invalid && (r_invalidCnt != '1)) begin
        r_invalidCnt <= r_invalidCnt + CNT_ONE;
      end
    end
  end

  // All outputs come from registers only.
  assign o_out_valid     = ~w_empty;
  assign o_out_order_ref = r_head.orderRef;
  assign o_out_seq       = r_head.seq;
  assign o_fifo_count    = r_wrPtr - r_rdPtr;
  assign o_full          = w_full;
  assign o_overflow_cnt  = r_overflowCnt;
  assign o_invalid_cnt   = r_invalidCnt;

endmodule

// File: tb/tb_delete_order_event_queue.sv
// tb_delete_order_event_queue
//
// Testbench for delete_order_event_queue: a hand-written vector table,
// directed multi-cycle corner cases (overflow, push+pop at full, async
// reset mid-stream, sequence wrap) and a randomized phase, all compared
// against a queue-based reference model.

module tb_delete_order_event_queue;

  localparam int DEPTH = 8;
  localparam int SEQ_W = 16;
  localparam int CNT_W = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int SEQ_MOD = 1 << SEQ_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dValid = 1'b0;
  logic              dInvalid = 1'b0;
  logic [63:0]       dRef = '0;
  logic              outReady = 1'b0;
  logic              outValid;
  logic [63:0]       outRef;
  logic [SEQ_W-1:0]  outSeq;
  logic [AW:0]       fifoCount;
  logic              fullFlag;
  logic [CNT_W-1:0]  overflowCnt;
  logic [CNT_W-1:0]  invalidCnt;

  int vectors = 0;
  int miscompares = 0;

  delete_order_event_queue #(
    .DEPTH(DEPTH), .SEQ_W(SEQ_W), .CNT_W(CNT_W)
  ) dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_delete_internal_valid (dValid),
    .i_delete_packet_invalid (dInvalid),
    .i_delete_order_ref      (dRef),
    .o_out_valid             (outValid),
    .i_out_ready             (outReady),
    .o_out_order_ref         (outRef),
    .o_out_seq               (outSeq),
    .o_fifo_count            (fifoCount),
    .o_full                  (fullFlag),
    .o_overflow_cnt          (overflowCnt),
    .o_invalid_cnt           (invalidCnt)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of {ref, seq} plus counters.
  typedef struct {
    logic [63:0] orderRef;
    int          seq;
  } ent_t;

  ent_t        mq[$];
  int          mNextSeq;
  int          mOvf;
  int          mInv;
  logic [63:0] mLastRef;
  int          mLastSeq;

  task automatic resetModel();
    mq.delete();
    mNextSeq = 0;
    mOvf     = 0;
    mInv     = 0;
    mLastRef = '0;
    mLastSeq = 0;
  endtask

  task automatic modelStep(input logic v, input logic inv, input logic [63:0] r, input logic rdy);
    bit   pop;
    bit   pushReq;
    bit   accept;
    ent_t tmp;
    pop     = (mq.size() > 0) && rdy;
    pushReq = v && !inv;
    accept  = pushReq && ((mq.size() < DEPTH) || pop);
    if (pop) tmp = mq.pop_front();
    if (accept) begin
      tmp.orderRef = r;
      tmp.seq      = mNextSeq;
      mq.push_back(tmp);
      mNextSeq = (mNextSeq + 1) % SEQ_MOD;
    end else if (pushReq && mOvf < CNT_MAX) begin
      mOvf++;
    end
    if (inv && mInv < CNT_MAX) mInv++;
    if (mq.size() > 0) begin
      mLastRef = mq[0].orderRef;
      mLastSeq = mq[0].seq;
    end
  endtask

  task automatic compare(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, ".valid"}, 64'(outValid), 64'(mq.size() > 0));
    compare({tag, ".ref"},   outRef, mLastRef);
    compare({tag, ".seq"},   64'(outSeq), 64'(mLastSeq));
    compare({tag, ".count"}, 64'(fifoCount), 64'(mq.size()));
    compare({tag, ".full"},  64'(fullFlag), 64'(mq.size() == DEPTH));
    compare({tag, ".ovf"},   64'(overflowCnt), 64'(mOvf));
    compare({tag, ".inv"},   64'(invalidCnt), 64'(mInv));
  endtask

  // Drive one cycle of inputs, advance model at the edge, check #1 later.
  task automatic applyStimulus(input logic v, input logic inv, input logic [63:0] r,
                               input logic rdy, input string tag);
    dValid   = v;
    dInvalid = inv;
    dRef     = r;
    outReady = rdy;
    @(posedge clk);
    modelStep(v, inv, r, rdy);
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset();
    dValid   = 1'b0;
    dInvalid = 1'b0;
    dRef     = '0;
    outReady = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    resetModel();
    checkOutput("reset");
  endtask

  typedef struct {
    logic        v;
    logic        inv;
    logic [63:0] orderRef;
    logic        rdy;
    logic        expValid;
    logic [63:0] expRef;
    int          expSeq;
    int          expCount;
    int          expInv;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Hand-computed expectations after each clock edge, starting from reset.
    vecs[0]  = '{1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 0, 1, 0};
    vecs[1]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 0, 0, 0};
    vecs[2]  = '{1'b1, 1'b0, 64'h1,  1'b0, 1'b1, 64'h1,  1, 1, 0};
    vecs[3]  = '{1'b1, 1'b0, 64'h2,  1'b0, 1'b1, 64'h1,  1, 2, 0};
    vecs[4]  = '{1'b1, 1'b0, 64'h3,  1'b0, 1'b1, 64'h1,  1, 3, 0};
    vecs[5]  = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 64'h1,  1, 3, 0};
    vecs[6]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 64'h2,  2, 2, 0};
    vecs[7]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 64'h3,  3, 1, 0};
    vecs[8]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h3,  3, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 64'hAA, 1'b1, 1'b0, 64'h3,  3, 0, 1};
    vecs[10] = '{1'b1, 1'b0, 64'hBB, 1'b0, 1'b1, 64'hBB, 4, 1, 1};
    vecs[11] = '{1'b0, 1'b1, 64'h0,  1'b1, 1'b0, 64'hBB, 4, 0, 2};
    vecs[12] = '{1'b1, 1'b0, 64'hCC, 1'b1, 1'b1, 64'hCC, 5, 1, 2};
    vecs[13] = '{1'b1, 1'b0, 64'hDD, 1'b1, 1'b1, 64'hDD, 6, 1, 2};
    vecs[14] = '{1'b0, 1'b0, 64'h0,  1'b0, 1'b1, 64'hDD, 6, 1, 2};

    // Table-driven directed vectors.
    doReset();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].v, vecs[i].inv, vecs[i].orderRef, vecs[i].rdy, "table");
      compare("tbl.valid", 64'(outValid), 64'(vecs[i].expValid));
      compare("tbl.ref", outRef, vecs[i].expRef);
      compare("tbl.seq", 64'(outSeq), 64'(vecs[i].expSeq));
      compare("tbl.count", 64'(fifoCount), 64'(vecs[i].expCount));
      compare("tbl.inv", 64'(invalidCnt), 64'(vecs[i].expInv));
    end

    // Overflow: DEPTH+2 pushes with no consumer, then push+pop at full.
    doReset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      applyStimulus(1'b1, 1'b0, 64'(100 + i), 1'b0, "fill");
    end
    compare("fill.full", 64'(fullFlag), 64'd1);
    compare("fill.count", 64'(fifoCount), 64'(DEPTH));
    compare("fill.ovf", 64'(overflowCnt), 64'd2);
    compare("fill.headSeq", 64'(outSeq), 64'd0);
    compare("fill.headRef", outRef, 64'd100);
    applyStimulus(1'b1, 1'b0, 64'd999, 1'b1, "fullpp");
    compare("fullpp.count", 64'(fifoCount), 64'(DEPTH));
    compare("fullpp.ovf", 64'(overflowCnt), 64'd2);
    compare("fullpp.full", 64'(fullFlag), 64'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      compare("drain.seq", 64'(outSeq), 64'(i));
      compare("drain.ref", outRef, (i == DEPTH) ? 64'd999 : 64'(100 + i));
      applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, "drain");
    end
    compare("drain.empty", 64'(fifoCount), 64'd0);

    // Asynchronous reset with four entries queued.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 64'(500 + i), 1'b0, "prerst");
    end
    dValid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    compare("arst.valid", 64'(outValid), 64'd0);
    compare("arst.count", 64'(fifoCount), 64'd0);
    compare("arst.ref", outRef, 64'd0);
    compare("arst.seq", 64'(outSeq), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    resetModel();
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, "postrst.idle");
    applyStimulus(1'b1, 1'b0, 64'hFEED, 1'b1, "postrst");
    compare("postrst.seq", 64'(outSeq), 64'd0);
    compare("postrst.ref", outRef, 64'hFEED);

    // Sequence wrap: 2^SEQ_W + 1 accepted events.
    doReset();
    for (int i = 0; i < SEQ_MOD + 1; i++) begin
      applyStimulus(1'b1, 1'b0, 64'(i), 1'b1, "wrap");
    end
    compare("wrap.seq", 64'(outSeq), 64'd0);
    compare("wrap.ref", outRef, 64'(SEQ_MOD));

    // Randomized traffic against the model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 6) == 0),
                    {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
